// File: rtl/operand_sched_pkg.sv
// Shared types and constants for the operand scheduler.
package operand_sched_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  localparam int unsigned NSLOT  = 4;
  localparam int unsigned SLOT_W = 2;

  // Width of a down-counter that must hold SETTLE-1.
  function automatic int unsigned cnt_width(input int unsigned settle);
    return (settle < 2) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/operand_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  int unsigned pos;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    pos   = 0;
    found = 1'b0;
    any   = |req;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/operand_sched.sv
// Round-robin sharing of the four operand registers between NREQ requesters,
// returning the settled block result to the granted requester.
module operand_sched
  import operand_sched_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned W      = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [2*NREQ-1:0]         req_slot,
  input  logic [W*NREQ-1:0]         req_data,
  input  logic                      clr,
  output logic [NREQ-1:0]           gnt,
  output logic [4*W-1:0]            op_bus,
  input  logic [W-1:0]              blk_out,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [W-1:0]              rsp_data,
  output logic                      busy
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = cnt_width(SETTLE);

  state_t                        state, state_nxt;
  logic [IW-1:0]                 ptr, ptr_nxt;
  logic [IW-1:0]                 cur, cur_nxt;
  logic [CW-1:0]                 cnt, cnt_nxt;
  logic [NSLOT-1:0][W-1:0]       op_nxt;
  logic [NREQ-1:0]               gnt_nxt;
  logic                          rsp_valid_nxt;
  logic [IW-1:0]                 rsp_id_nxt;
  logic [W-1:0]                  rsp_data_nxt;

  logic [NREQ-1:0]               arb_gnt;
  logic [IW-1:0]                 arb_idx;
  logic                          arb_any;
  logic [SLOT_W-1:0]             win_slot;
  logic [W-1:0]                  win_data;

  rr_arbiter #(
    .N(NREQ)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign win_slot = req_slot[SLOT_W*arb_idx +: SLOT_W];
  assign win_data = req_data[W*arb_idx +: W];
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    cur_nxt       = cur;
    cnt_nxt       = cnt;
    op_nxt        = op_bus;
    gnt_nxt       = '0;
    rsp_valid_nxt = 1'b0;
    rsp_id_nxt    = rsp_id;
    rsp_data_nxt  = rsp_data;
    unique case (state)
      IDLE: begin
        // clr wins over any pending request and suppresses the grant
        if (clr) begin
          op_nxt = '0;
        end else if (arb_any) begin
          gnt_nxt          = arb_gnt;
          op_nxt[win_slot] = win_data;
          ptr_nxt          = (arb_idx == IW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
          cur_nxt          = arb_idx;
          cnt_nxt          = CW'(SETTLE-1);
          state_nxt        = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          rsp_data_nxt  = blk_out;
          rsp_id_nxt    = cur;
          rsp_valid_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cur       <= '0;
      cnt       <= '0;
      op_bus    <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cur       <= cur_nxt;
      cnt       <= cnt_nxt;
      op_bus    <= op_nxt;
      gnt       <= gnt_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_id    <= rsp_id_nxt;
      rsp_data  <= rsp_data_nxt;
    end
  end

endmodule

// File: tb/tb_operand_sched.sv
// Directed self-checking bench for operand_sched (NREQ=4, W=4, SETTLE=2).
module tb_operand_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  req_slot;
  logic [15:0] req_data;
  logic        clr;
  logic [3:0]  gnt;
  logic [15:0] op_bus;
  logic [3:0]  blk_out;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_data;
  logic        busy;

  int tests;
  int fails;

  // block model: result follows operand slot 3
  assign blk_out = op_bus[15:12];

  operand_sched #(
    .NREQ  (4),
    .W     (4),
    .SETTLE(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_slot (req_slot),
    .req_data (req_data),
    .clr      (clr),
    .gnt      (gnt),
    .op_bus   (op_bus),
    .blk_out  (blk_out),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; req_slot = 8'hE4; req_data = 16'h4321; clr = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      tests++; if (op_bus !== 16'h0000) begin fails++; $display("FAIL reset_op_bus: got %h expected 0000", op_bus); end
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    end
    tests++; if (rsp_id !== 2'd0 || rsp_data !== 4'h0) begin fails++; $display("FAIL reset_rsp: got id %0d data %h expected 0 0", rsp_id, rsp_data); end
    rst = 1'b0; req = 4'b0000;
  endtask

  task automatic test_round_robin();
    int        order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;
    // every requester targets slot 3 with data id+1
    req = 4'b1111; req_slot = 8'hFF; req_data = 16'h4321;
    for (int k = 1; k <= 13; k++) begin
      tick();
      exp_g = (k % 3 == 1) ? (4'b0001 << order[k/3]) : 4'b0000;
      tests++; if (gnt !== exp_g) begin fails++; $display("FAIL rr_gnt_%0d: got %b expected %b", k, gnt, exp_g); end
      if (k % 3 == 0) begin
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(order[k/3-1]) || rsp_data !== 4'(order[k/3-1] + 1)) begin
          fails++;
          $display("FAIL rr_rsp_%0d: got v%b id%0d d%h expected v1 id%0d d%h", k, rsp_valid, rsp_id, rsp_data, order[k/3-1], order[k/3-1] + 1);
        end
      end
    end
    req = 4'b0000;
    for (int k = 0; k < 3; k++) tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rr_drain_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    // slot 3 currently holds 1 from the last round-robin grant
    req = 4'b0100; req_slot = 8'b00_11_00_00; req_data = 16'h0A00;
    tick();
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL single_gnt: got %b expected 0100", gnt); end
    tests++; if (op_bus !== 16'hA000) begin fails++; $display("FAIL single_op_bus: got %h expected a000", op_bus); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b expected 1", busy); end
    req = 4'b0000;
    tick();
    tests++; if (gnt !== 4'b0000 || rsp_valid !== 1'b0) begin fails++; $display("FAIL single_mid: got gnt %b v%b expected 0000 v0", gnt, rsp_valid); end
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 4'hA) begin fails++; $display("FAIL single_rsp: got v%b id%0d d%h expected v1 id2 da", rsp_valid, rsp_id, rsp_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle: got %b expected 0", busy); end
    tick();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_strobe: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_wrap();
    // ptr is now 3; requester 3 writes slot 1 <- 5, requester 0 writes slot 0 <- 6
    req = 4'b1001; req_slot = 8'b01_00_00_00; req_data = 16'h5006;
    tick();
    tests++; if (gnt !== 4'b1000 || op_bus !== 16'hA050) begin fails++; $display("FAIL wrap_first: got gnt %b op %h expected 1000 a050", gnt, op_bus); end
    tick();
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || gnt !== 4'b0000) begin fails++; $display("FAIL wrap_rsp3: got v%b id%0d gnt %b expected v1 id3 0000", rsp_valid, rsp_id, gnt); end
    tick();
    tests++; if (gnt !== 4'b0001 || op_bus !== 16'hA056) begin fails++; $display("FAIL wrap_second: got gnt %b op %h expected 0001 a056", gnt, op_bus); end
    req = 4'b0000;
    tick();
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 4'hA) begin fails++; $display("FAIL wrap_rsp0: got v%b id%0d d%h expected v1 id0 da", rsp_valid, rsp_id, rsp_data); end
  endtask

  task automatic test_clr();
    clr = 1'b1; req = 4'b0001; req_slot = 8'h00; req_data = 16'h0007;
    tick();
    tests++; if (gnt !== 4'b0000 || op_bus !== 16'h0000 || busy !== 1'b0) begin fails++; $display("FAIL clr_prio: got gnt %b op %h busy %b expected 0000 0000 0", gnt, op_bus, busy); end
    clr = 1'b0;
    tick();
    tests++; if (gnt !== 4'b0001 || op_bus !== 16'h0007) begin fails++; $display("FAIL clr_after: got gnt %b op %h expected 0001 0007", gnt, op_bus); end
    req = 4'b0000; clr = 1'b1;
    tick();
    tests++; if (op_bus !== 16'h0007) begin fails++; $display("FAIL clr_wait1: got %h expected 0007", op_bus); end
    tick();
    tests++; if (op_bus !== 16'h0007 || rsp_valid !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL clr_wait2: got op %h v%b busy %b expected 0007 v1 0", op_bus, rsp_valid, busy); end
    clr = 1'b0;
    tick();
    tests++; if (op_bus !== 16'h0007) begin fails++; $display("FAIL clr_released: got %h expected 0007", op_bus); end
  endtask

  task automatic test_reset_mid_op();
    req = 4'b0010; req_slot = 8'b00_00_10_00; req_data = 16'h0090;
    tick();
    tests++; if (gnt !== 4'b0010 || op_bus !== 16'h0907) begin fails++; $display("FAIL rmid_gnt: got gnt %b op %h expected 0010 0907", gnt, op_bus); end
    req = 4'b0000; rst = 1'b1;
    tick();
    tests++; if (gnt !== 4'b0000 || op_bus !== 16'h0000 || rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rmid_reset: got gnt %b op %h v%b busy %b expected 0000 0000 v0 0", gnt, op_bus, rsp_valid, busy); end
    rst = 1'b0;
    tick();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rmid_no_rsp: got %b expected 0", rsp_valid); end
    // with ptr back at 0, requester 1 beats requester 2
    req = 4'b0110; req_slot = 8'b00_10_01_00; req_data = 16'h0430;
    tick();
    tests++; if (gnt !== 4'b0010 || op_bus !== 16'h0030) begin fails++; $display("FAIL rmid_regrant: got gnt %b op %h expected 0010 0030", gnt, op_bus); end
    req = 4'b0000;
    tick();
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 4'h0) begin fails++; $display("FAIL rmid_rsp: got v%b id%0d d%h expected v1 id1 d0", rsp_valid, rsp_id, rsp_data); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_clr();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operand_sched.md
Name: operand_sched

Overview:
- Shares the four 4-bit operand registers of the compute block between NREQ independent requesters.
- Each request writes one value into one operand slot, waits SETTLE cycles for the block output to settle, then returns the sampled result to the requester, tagged with its id.
- Arbitration is round-robin, one transaction in flight at a time.
- Sits between the pad-level input logic and the block instance; it replaces the direct per-slot load enables.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 4, operand and result width
- SETTLE, 2, cycles from operand update to result sample (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req  in  NREQ  per-requester request, level
- req_slot  in  2*NREQ  slot index per requester; bits [2i+1:2i] belong to requester i
- req_data  in  W*NREQ  value per requester; bits [W*i+W-1:W*i] belong to requester i
- clr  in  1  clear all operand slots to 0
- gnt  out  NREQ  one-hot grant pulse, registered
- op_bus  out  4*W  operand registers to the block; slot k at [W*k+W-1:W*k]
- blk_out  in  W  block result
- rsp_valid  out  1  one-cycle result strobe
- rsp_id  out  $clog2(NREQ)  requester id of the result
- rsp_data  out  W  sampled blk_out
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port rst.
- Reset values:
  - state=IDLE, rr pointer=0, op_bus=0, gnt=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
- Reset mid-transaction: the in-flight transaction is dropped, no rsp_valid is issued, and all registers return to reset values at that edge.
- States: IDLE, WAIT.
- IDLE, clr=1 at edge: all four slots <= 0; stay IDLE; no grant this edge. clr beats req.
- IDLE, clr=0 and any req at edge E0:
  - Winner i is the first set bit searching ptr, ptr+1, ... mod NREQ.
  - gnt[i]<=1 for exactly one cycle.
  - Slot req_slot[i] <= req_data[i]; other slots are unchanged.
  - ptr <= (i+1) mod NREQ; cnt <= SETTLE-1; state <= WAIT.
- WAIT:
  - gnt<=0.
  - cnt!=0: cnt--.
  - cnt==0: rsp_data<=blk_out, rsp_id<=i, rsp_valid<=1 (one cycle), state<=IDLE.
- Latency:
  - rsp_valid is high SETTLE cycles after the gnt cycle.
  - blk_out is sampled SETTLE edges after op_bus changed.
  - A new grant is possible at the edge after rsp_valid rises, giving one transaction per SETTLE+1 cycles.
- Request handshake: a request is consumed by its gnt. The requester must drop req (or present a new slot/data) by the edge after gnt. A req still high on return to IDLE is treated as a new request.
- clr and req are ignored in WAIT. A clr must be held until busy=0 to take effect.
- Pointer wrap: ptr at NREQ-1 wraps to 0. A requester that has just been granted becomes lowest priority.
- op_bus is registered. Slots are never written except by a grant or clr.

Decomposition:
- Package operand_sched_pkg:
  - state enum {IDLE, WAIT}
  - NSLOT=4, SLOT_W=2
  - counter width $clog2(SETTLE+1)
- Sub-module rr_arbiter (params N):
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, binary index, any-request flag.
  - Combinational.
- The FSM, slot registers and response registers stay in operand_sched.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, op_bus=0, rsp_valid=0, busy=0 throughout.
- Single request: req[2]=1, slot=3, data=4'hA, blk_out tracks op slot 3 -> gnt=4'b0100 one cycle; op_bus[15:12]=A next cycle; rsp_valid, rsp_id=2, rsp_data=A exactly 2 cycles after gnt.
- Round robin: req=4'b1111 held continuously -> grants in order 0,1,2,3,0, spaced 3 cycles apart (SETTLE=2).
- Wrap/fairness: ptr=3 and req=4'b1001 -> gnt to 3, then 0; never 3 twice while 0 waits.
- clr priority: clr=1 and req[0]=1 in same IDLE cycle -> all slots 0, no gnt that edge, gnt[0] the edge after clr drops. clr during WAIT -> no effect on op_bus.
- Reset mid-op: assert rst one cycle after gnt -> no rsp_valid, op_bus=0, ptr=0; next request from req[1] is granted normally.
